sweep_sequencer: RTL and testbench
==================================

# sweep_sequencer

Calibration sequencer for the two-axis tracker servos. It runs a full horizontal sweep, sampling the light sensor at every position, and returns the horizontal servo to the brightest position. It then does the same on the vertical axis. It sits between the top-level mode logic (which pulses START) and the servo step drivers. It replaces free-running sweep enables with a deterministic, cycle-exact schedule.

## Interface
- SWEEP_LEN, 16: positions per axis sweep (≥2). POS_W = $clog2(SWEEP_LEN).
- SETTLE, 4: cycles per position window (≥2).
- LIGHT_W, 10: light sensor sample width.

- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- START  in  1  begin calibration; sampled only in IDLE.
- LIGHT  in  LIGHT_W  unsigned sensor value, valid every cycle.
- STEP_H  out  1  one-cycle horizontal servo step pulse.
- STEP_V  out  1  one-cycle vertical servo step pulse.
- DIR  out  1  step direction: 1 = forward (position +1), 0 = reverse.
- BUSY  out  1  high in every non-IDLE state.
- DONE  out  1  one-cycle pulse when calibration completes.
- BEST_H  out  POS_W  brightest horizontal position index.
- BEST_V  out  POS_W  brightest vertical position index.
- BEST_LIGHT  out  LIGHT_W  peak value of the most recent axis sweep.

## Operation
- States: IDLE, H_SWEEP, H_RETURN, V_SWEEP, V_RETURN, FINISH.
- IDLE → H_SWEEP on START=1.
  - Position counter = 0 and window counter = 0 on entry.
  - START requires both servos at position 0.
  - START is ignored in every other state.
- Position window: SETTLE cycles, back to back, with no gap between windows or between states.
- H_SWEEP / V_SWEEP:
  - Window k (0 ≤ k < SWEEP_LEN): for k > 0, the step pulse on the active axis is high in the window's first cycle with DIR=1.
  - LIGHT is sampled on the edge closing the window's last cycle.
  - k=0 loads best unconditionally.
  - For k>0, best is updated only if LIGHT > BEST_LIGHT (strict), so on ties the earliest position wins.
  - After window SWEEP_LEN-1, go to the RETURN state.
- H_RETURN / V_RETURN:
  - R = SWEEP_LEN-1-best windows, each with the step pulse in its first cycle and DIR=0. No sampling.
  - R=0: the state lasts zero cycles; H_RETURN passes straight to V_SWEEP, V_RETURN straight to FINISH.
- V_SWEEP entry: resets position and window counters. BEST_LIGHT is overwritten by the vertical k=0 sample.
- FINISH: DONE=1 for one cycle, then IDLE. BEST_H, BEST_V and BEST_LIGHT hold until the next START.
- STEP_H and STEP_V are never high together.
- DIR is 0 whenever no step pulse is active.

## Timing
- Reset values: STEP_H=0, STEP_V=0, DIR=0, BUSY=0, DONE=0, BEST_H=0, BEST_V=0, BEST_LIGHT=0. State is IDLE.
- All outputs are registered.
- START sampled at edge e0:
  - BUSY=1 and H_SWEEP window 0 begin in cycle 0 (the cycle after e0).
  - Total cycles T = (2·SWEEP_LEN + Rh + Rv)·SETTLE.
  - DONE is high in cycle T; BUSY falls in cycle T+1.
- Reset asserted mid-operation: all outputs return to reset values immediately (asynchronous). Any step pulse in flight is cut. The servos are not re-homed.

## Configuration
- SWEEP_ABORT_EN defined:
  - Adds input ABORT (1 bit).
  - ABORT=1 in any non-IDLE state → IDLE on the next edge. STEP_H/STEP_V/DIR go low, BUSY goes low, DONE is not pulsed.
  - BEST_* keep their partial values.
  - ABORT has priority over a same-cycle state transition.
- SWEEP_ABORT_EN undefined: the ABORT port does not exist, and a sweep always runs to FINISH or reset.

## Test plan
- Defaults. LIGHT=900 at H position 5 and at V position 11, else 100.
  - BEST_H=5, BEST_V=11, BEST_LIGHT=900.
  - 15+10 STEP_H pulses, 15+4 STEP_V pulses.
  - DONE high exactly in cycle 184.
- Peak at final position 15 on both axes: no return steps, DONE in cycle 128.
- Tie: LIGHT=500 at H positions 3 and 9, else 0 → BEST_H=3.
- START pulsed again at cycle 50 while BUSY → ignored; DONE timing is unchanged.
- RST_N low at cycle 70 → all outputs 0 immediately. A subsequent START runs a full fresh sequence.
- SWEEP_ABORT_EN: ABORT at cycle 80 during V_SWEEP → IDLE at cycle 81, no DONE, BEST_H retained.

Source files
------------

// File: rtl/sweep_sequencer_if.sv
// rtl/sweep_sequencer_if.sv - control/sensor bundle between mode logic, light sensor and the sweep sequencer.
// The abort input exists only when SWEEP_ABORT_EN is defined.
interface sweep_sequencer_if #(
  parameter int SWEEP_LEN = 16,
  parameter int LIGHT_W   = 10
);
  localparam int POS_W = $clog2(SWEEP_LEN);

  logic               start;
  logic [LIGHT_W-1:0] light;
  logic               step_h;
  logic               step_v;
  logic               dir;
  logic               busy;
  logic               done;
  logic [POS_W-1:0]   best_h;
  logic [POS_W-1:0]   best_v;
  logic [LIGHT_W-1:0] best_light;
`ifdef SWEEP_ABORT_EN
  logic               abort;

  modport master (output start, light, abort,
                  input  step_h, step_v, dir, busy, done, best_h, best_v, best_light);
  modport slave  (input  start, light, abort,
                  output step_h, step_v, dir, busy, done, best_h, best_v, best_light);
`else
  modport master (output start, light,
                  input  step_h, step_v, dir, busy, done, best_h, best_v, best_light);
  modport slave  (input  start, light,
                  output step_h, step_v, dir, busy, done, best_h, best_v, best_light);
`endif
endinterface

// File: rtl/sweep_sequencer.sv
// rtl/sweep_sequencer.sv - two-axis sweep/peak-return calibration sequencer, cycle-exact window schedule.
// Optional SWEEP_ABORT_EN adds an abort input that drops any running sequence back to IDLE.
module sweep_sequencer #(
  parameter int SWEEP_LEN = 16,
  parameter int SETTLE    = 4,
  parameter int LIGHT_W   = 10
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  sweep_sequencer_if.slave   bus
);
  localparam int POS_W = $clog2(SWEEP_LEN);
  localparam int WIN_W = $clog2(SETTLE);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] H_SWEEP  = 3'd1;
  localparam logic [2:0] H_RETURN = 3'd2;
  localparam logic [2:0] V_SWEEP  = 3'd3;
  localparam logic [2:0] V_RETURN = 3'd4;
  localparam logic [2:0] FINISH   = 3'd5;

  localparam logic [POS_W-1:0] LAST_POS = POS_W'(SWEEP_LEN - 1);
  localparam logic [WIN_W-1:0] LAST_WIN = WIN_W'(SETTLE - 1);

  logic [2:0]         state_q, state_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic [WIN_W-1:0]   win_q, win_d;
  logic [POS_W-1:0]   best_h_q, best_h_d;
  logic [POS_W-1:0]   best_v_q, best_v_d;
  logic [LIGHT_W-1:0] best_light_q, best_light_d;
  logic               step_h_q, step_h_d;
  logic               step_v_q, step_v_d;
  logic               dir_q, dir_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               axis_v, win_end, take, step_req, abort_req;
  logic [POS_W-1:0]   cur_best, sweep_best;

  always_comb begin
    axis_v     = (state_q == V_SWEEP) || (state_q == V_RETURN);
    win_end    = (win_q == LAST_WIN);
    cur_best   = axis_v ? best_v_q : best_h_q;
    // Position 0 always loads; later positions need a strictly brighter sample.
    take       = (pos_q == '0) || (bus.light > best_light_q);
    sweep_best = take ? pos_q : cur_best;
`ifdef SWEEP_ABORT_EN
    abort_req  = bus.abort && (state_q != IDLE);
`else
    abort_req  = 1'b0;
`endif

    state_d      = state_q;
    pos_d        = pos_q;
    win_d        = win_q;
    best_h_d     = best_h_q;
    best_v_d     = best_v_q;
    best_light_d = best_light_q;
    step_req     = 1'b0;
    dir_d        = 1'b0;
    done_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = H_SWEEP;
          pos_d   = '0;
          win_d   = '0;
        end
      end
      H_SWEEP, V_SWEEP: begin
        win_d = win_q + 1'b1;
        if (win_end) begin
          win_d = '0;
          if (take) begin
            best_light_d = bus.light;
            if (axis_v) best_v_d = pos_q;
            else        best_h_d = pos_q;
          end
          if (pos_q != LAST_POS) begin
            pos_d    = pos_q + 1'b1;
            step_req = 1'b1;
            dir_d    = 1'b1;
          end else if (sweep_best != LAST_POS) begin
            state_d  = axis_v ? V_RETURN : H_RETURN;
            pos_d    = LAST_POS - 1'b1;
            step_req = 1'b1;
          end else if (axis_v) begin
            state_d = FINISH;
            done_d  = 1'b1;
          end else begin
            state_d = V_SWEEP;
            pos_d   = '0;
          end
        end
      end
      H_RETURN, V_RETURN: begin
        // pos_q tracks the servo; each window's leading step moves it one back toward best.
        win_d = win_q + 1'b1;
        if (win_end) begin
          win_d = '0;
          if (pos_q != cur_best) begin
            pos_d    = pos_q - 1'b1;
            step_req = 1'b1;
          end else if (axis_v) begin
            state_d = FINISH;
            done_d  = 1'b1;
          end else begin
            state_d = V_SWEEP;
            pos_d   = '0;
          end
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (abort_req) begin
      state_d      = IDLE;
      step_req     = 1'b0;
      dir_d        = 1'b0;
      done_d       = 1'b0;
      best_h_d     = best_h_q;
      best_v_d     = best_v_q;
      best_light_d = best_light_q;
    end

    step_h_d = step_req & ~axis_v;
    step_v_d = step_req &  axis_v;
    busy_d   = (state_d != IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= IDLE;
      pos_q        <= '0;
      win_q        <= '0;
      best_h_q     <= '0;
      best_v_q     <= '0;
      best_light_q <= '0;
      step_h_q     <= 1'b0;
      step_v_q     <= 1'b0;
      dir_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pos_q        <= pos_d;
      win_q        <= win_d;
      best_h_q     <= best_h_d;
      best_v_q     <= best_v_d;
      best_light_q <= best_light_d;
      step_h_q     <= step_h_d;
      step_v_q     <= step_v_d;
      dir_q        <= dir_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign bus.step_h     = step_h_q;
  assign bus.step_v     = step_v_q;
  assign bus.dir        = dir_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.best_h     = best_h_q;
  assign bus.best_v     = best_v_q;
  assign bus.best_light = best_light_q;
endmodule

// File: tb/tb_sweep_sequencer.sv
// tb/tb_sweep_sequencer.sv - randomized self-checking bench for sweep_sequencer against a schedule/argmax model.
module tb_sweep_sequencer;
  localparam int L  = 16;
  localparam int S  = 4;
  localparam int LW = 10;
  localparam int PW = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sweep_sequencer_if #(.SWEEP_LEN(L), .LIGHT_W(LW)) bus ();

  sweep_sequencer #(.SWEEP_LEN(L), .SETTLE(S), .LIGHT_W(LW)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  int checks   = 0;
  int failures = 0;
  int lh[L];
  int lv[L];
  int last_done;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Brightest position, earliest one on ties.
  function automatic int peak_pos(input bit vert);
    int best = 0;
    for (int k = 1; k < L; k++) begin
      if (vert ? (lv[k] > lv[best]) : (lh[k] > lh[best])) best = k;
    end
    return best;
  endfunction

  // Profile value only in each window's last cycle; junk elsewhere catches early sampling.
  function automatic logic [LW-1:0] light_at(input int c, input int rh);
    int vs = (L + rh) * S;
    if ((c % S) != S - 1) return LW'($urandom);
    if (c < L * S) return LW'(lh[c / S]);
    if (c >= vs && c < vs + L * S) return LW'(lv[(c - vs) / S]);
    return LW'($urandom);
  endfunction

  function automatic logic [31:0] outs_packed();
    return {9'd0, bus.step_h, bus.step_v, bus.dir, bus.busy, bus.done,
            bus.best_h, bus.best_v, bus.best_light};
  endfunction

  task automatic set_peaks(input int ph, input int pv, input int hi, input int lo);
    for (int k = 0; k < L; k++) begin
      lh[k] = (k == ph) ? hi : lo;
      lv[k] = (k == pv) ? hi : lo;
    end
  endtask

  task automatic run_seq(input string tag, input int restart_at, input int rst_at, input int abort_at);
    int bh, bv, rh, rv, t, cyc, done_cyc, ndone, nh, nv, hpos, vpos, viol, busy_end;
    bit cut;
    bh = peak_pos(1'b0);
    bv = peak_pos(1'b1);
    rh = L - 1 - bh;
    rv = L - 1 - bv;
    t  = (2 * L + rh + rv) * S;
    done_cyc = -1; busy_end = -1; ndone = 0; nh = 0; nv = 0;
    hpos = 0; vpos = 0; viol = 0; cut = 1'b0;

    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    cyc = 0;
    while (busy_end < 0 && !cut && cyc < t + 20) begin
      bus.light = light_at(cyc, rh);
      bus.start = (cyc == restart_at);
`ifdef SWEEP_ABORT_EN
      bus.abort = (cyc == abort_at);
`endif
      @(negedge clk);
      if (bus.step_h && bus.step_v) viol++;
      if (!bus.step_h && !bus.step_v && bus.dir) viol++;
      if (bus.step_h) begin nh++; hpos += bus.dir ? 1 : -1; end
      if (bus.step_v) begin nv++; vpos += bus.dir ? 1 : -1; end
      if (bus.done) begin ndone++; done_cyc = cyc; end
      if (!bus.busy) busy_end = cyc;
      if (cyc == rst_at) begin
        chk({tag, "_pre_rst_busy"}, 32'(bus.busy), 32'd1);
        chk({tag, "_pre_rst_best_h"}, 32'(bus.best_h), 32'(bh));
        #1 rst_n = 1'b0;
        #1 chk({tag, "_async_rst_outs"}, outs_packed(), 32'd0);
        cut = 1'b1;
      end else begin
        @(posedge clk);
        #1;
        cyc++;
      end
    end
    bus.start = 1'b0;
`ifdef SWEEP_ABORT_EN
    bus.abort = 1'b0;
    if (abort_at >= 0) begin
      chk({tag, "_abort_idle_cyc"}, 32'(busy_end), 32'(abort_at + 1));
      chk({tag, "_abort_no_done"}, 32'(ndone), 32'd0);
      chk({tag, "_abort_best_h"}, 32'(bus.best_h), 32'(bh));
      chk({tag, "_abort_step_dir"}, 32'({bus.step_h, bus.step_v, bus.dir}), 32'd0);
    end else
`endif
    if (!cut) begin
      last_done = done_cyc;
      chk({tag, "_done_cyc"}, 32'(done_cyc), 32'(t));
      chk({tag, "_busy_fall"}, 32'(busy_end), 32'(t + 1));
      chk({tag, "_done_cnt"}, 32'(ndone), 32'd1);
      chk({tag, "_best_h"}, 32'(bus.best_h), 32'(bh));
      chk({tag, "_best_v"}, 32'(bus.best_v), 32'(bv));
      chk({tag, "_best_light"}, 32'(bus.best_light), 32'(lv[bv]));
      chk({tag, "_steps_h"}, 32'(nh), 32'(L - 1 + rh));
      chk({tag, "_steps_v"}, 32'(nv), 32'(L - 1 + rv));
      chk({tag, "_servo_h"}, 32'(hpos), 32'(bh));
      chk({tag, "_servo_v"}, 32'(vpos), 32'(bv));
      chk({tag, "_step_dir_rules"}, 32'(viol), 32'd0);
    end
  endtask

  initial begin
    int rng;
    bus.start = 1'b0;
    bus.light = '0;
`ifdef SWEEP_ABORT_EN
    bus.abort = 1'b0;
`endif
    last_done = -1;
    repeat (3) @(posedge clk);
    #1 chk("reset_outs", outs_packed(), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk) chk("idle_outs", outs_packed(), 32'd0);

    set_peaks(5, 11, 900, 100);
    run_seq("dflt", -1, -1, -1);
    chk("dflt_done_184", 32'(last_done), 32'd184);

    set_peaks(15, 15, 900, 100);
    run_seq("peak15", -1, -1, -1);
    chk("peak15_done_128", 32'(last_done), 32'd128);

    set_peaks(3, 0, 500, 0);
    lh[9] = 500;
    for (int k = 0; k < L; k++) lv[k] = $urandom_range(0, 1023);
    run_seq("tie", -1, -1, -1);

    set_peaks(5, 11, 900, 100);
    run_seq("restart", 50, -1, -1);

    run_seq("rst", -1, 70, -1);
    @(negedge clk) rst_n = 1'b1;
    run_seq("post_rst", -1, -1, -1);

    for (int r = 0; r < 8; r++) begin
      rng = ($urandom_range(0, 1) == 1) ? 1023 : 3;
      for (int k = 0; k < L; k++) begin
        lh[k] = $urandom_range(0, rng);
        lv[k] = $urandom_range(0, rng);
      end
      run_seq($sformatf("rand%0d", r), -1, -1, -1);
    end

`ifdef SWEEP_ABORT_EN
    set_peaks(15, 15, 900, 100);
    run_seq("abort", -1, -1, 80);
    run_seq("post_abort", -1, -1, -1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
